// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = A - B - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q;
    logic             b_msb_q;
    logic             ovf_q;
`endif

    logic             d_bit_d;
    logic             borrow_d;
    logic [WIDTH-1:0] diff_d;

    // Full-subtractor cell on the current LSBs and the held borrow.
    always_comb begin
        d_bit_d  = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
        borrow_d = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);
        diff_d   = {d_bit_d, diff_q[WIDTH-1:1]};
    end

    // Control FSM with operand/result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q   <= A;
                        b_sr_q   <= B;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        diff_q   <= '0;
                        bout_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q  <= A[WIDTH-1];
                        b_msb_q  <= B[WIDTH-1];
                        ovf_q    <= 1'b0;
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
                    borrow_q <= borrow_d;
                    diff_q   <= diff_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // Last bit: d_bit_d becomes diff MSB, borrow_d is the word borrow-out.
                        bout_q  <= borrow_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= (a_msb_q ^ b_msb_q) & (d_bit_d ^ a_msb_q);
`endif
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, back-to-back, mid-op reset
// and randomized operands checked against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         bin   = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         busy;
    logic         done;
    logic         bout;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_diff = '0;
    logic         exp_bout = 1'b0;
    logic         exp_ovf  = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    // Reference: plain integer arithmetic, unsigned for diff/bout, signed for overflow.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        int r;
        int sr;
        r  = int'(a) - int'(b) - int'(bi);
        sr = int'($signed(a)) - int'($signed(b)) - int'(bi);
        exp_diff = W'(r);
        exp_bout = (r < 0);
        exp_ovf  = (sr > 127) || (sr < -128);
    endtask

    // mode 0: quiet while busy; 1: random start/operand noise; 2: start held high.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input int mode);
        A = a; B = b; bin = bi; start = 1'b1;
        model(a, b, bi);
        @(negedge clk);
        check("busy_after_accept", {busy, done}, 2'b10);
        for (int k = 1; k <= W; k++) begin
            if (mode == 1) begin
                start = 1'($urandom_range(0, 1));
                A = W'($urandom); B = W'($urandom); bin = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                start = 1'b1;
                A = W'($urandom); B = W'($urandom); bin = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (k < W) check("busy_shift", {busy, done}, 2'b10);
        end
        check("done_pulse", {busy, done}, 2'b01);
        check("diff", diff, exp_diff);
        check("bout", bout, exp_bout);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", ovf, exp_ovf);
`endif
        start = 1'b0;
    endtask

    task automatic idle_hold();
        @(negedge clk);
        check("idle_state", {busy, done}, 2'b00);
        check("hold_diff", diff, exp_diff);
        check("hold_bout", bout, exp_bout);
    endtask

    initial begin
        int done_seen;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, 8'h00);
        check("rst_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk);

        do_op(8'h35, 8'h12, 1'b0, 0); idle_hold();
        do_op(8'h12, 8'h35, 1'b0, 1); idle_hold();
        do_op(8'h00, 8'h01, 1'b0, 0); idle_hold();
        do_op(8'h10, 8'h0F, 1'b1, 1); idle_hold();
        do_op(8'h00, 8'h00, 1'b1, 0); idle_hold();
        do_op(8'h80, 8'h01, 1'b0, 0); idle_hold();
        do_op(8'h05, 8'h03, 1'b0, 1); idle_hold();
        do_op(8'hFF, 8'h7F, 1'b1, 0); idle_hold();

        // Back-to-back: the DONE cycle accepts the next start directly.
        for (int i = 0; i < 4; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 2);
        idle_hold();

        // Reset four cycles into an operation.
        A = 8'hA5; B = 8'h3C; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_diff", diff, 8'h00);
        check("midrst_bout", bout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        do_op(8'hA5, 8'h3C, 1'b1, 0); idle_hold();

        for (int i = 0; i < 30; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) idle_hold();
        end
        idle_hold();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
